// File: rtl/cla_add_arbiter.sv
// cla_add_arbiter: round-robin sequencer sharing one combinational adder among NUM_REQ requesters; optional stats via CLA_ARB_STATS_EN
module cla_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int ADD_LAT = 2,
  parameter int ID_W    = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
  output logic [WIDTH-1:0]         o_add_a,
  output logic [WIDTH-1:0]         o_add_b,
  input  logic [WIDTH-1:0]         i_add_sum,
  input  logic                     i_add_cout,
  output logic                     o_rsp_valid,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [WIDTH-1:0]         o_rsp_sum,
`ifdef CLA_ARB_STATS_EN
  output logic [31:0]              o_op_count,
  output logic [31:0]              o_busy_cycles,
`endif
  output logic                     o_rsp_cout
);
  localparam int CNT_W = ADD_LAT > 1 ? $clog2(ADD_LAT) : 1;
  localparam int NPAD = 2 ** ID_W;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t               r_state;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [ID_W-1:0]      r_gnt_id;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_op_a;
  logic [WIDTH-1:0]     r_op_b;
  logic                 r_rsp_valid;
  logic [ID_W-1:0]      r_rsp_id;
  logic [WIDTH-1:0]     r_rsp_sum;
  logic                 r_rsp_cout;
  logic [2*NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0]   w_lo;
  logic [NUM_REQ-1:0]   w_iso;
  logic [2*NUM_REQ-1:0] w_back;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [ID_W-1:0]      w_win;
  logic                 w_found;
  logic [WIDTH-1:0]     w_ra [NPAD];
  logic [WIDTH-1:0]     w_rb [NPAD];
  // Rotate valids so rr_ptr sits at bit 0, isolate the lowest set bit, rotate the one-hot back
  always_comb begin
    w_rot   = {i_req_valid, i_req_valid} >> r_rr_ptr;
    w_lo    = w_rot[NUM_REQ-1:0];
    w_iso   = w_lo & (~w_lo + NUM_REQ'(1));
    w_back  = {NUM_REQ'(0), w_iso} << r_rr_ptr;
    w_gnt   = w_back[NUM_REQ-1:0] | w_back[2*NUM_REQ-1:NUM_REQ];
    w_found = |i_req_valid;
  end
  for (genvar b = 0; b < ID_W; b++) begin : g_enc
    logic [NUM_REQ-1:0] w_m;
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bit
      assign w_m[g] = ((g >> b) & 1) != 0 ? w_gnt[g] : 1'b0;
    end
    assign w_win[b] = |w_m;
  end
  for (genvar g = 0; g < NPAD; g++) begin : g_unpack
    if (g < NUM_REQ) begin : g_real
      assign w_ra[g] = i_req_a[g*WIDTH +: WIDTH];
      assign w_rb[g] = i_req_b[g*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_ra[g] = '0;
      assign w_rb[g] = '0;
    end
  end
  assign o_req_ready = (r_state == IDLE && !i_reset) ? w_gnt : '0;
  assign o_add_a     = r_op_a;
  assign o_add_b     = r_op_b;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_cout  = r_rsp_cout;
  // Grant in IDLE, hold operands for ADD_LAT cycles in BUSY, pulse the response in DONE
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_gnt_id    <= '0;
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_found) begin
          r_op_a   <= w_ra[w_win];
          r_op_b   <= w_rb[w_win];
          r_gnt_id <= w_win;
          r_cnt    <= CNT_W'(ADD_LAT - 1);
          r_state  <= BUSY;
        end
        BUSY: if (r_cnt == '0) begin
          r_rsp_sum   <= i_add_sum;
          r_rsp_cout  <= i_add_cout;
          r_rsp_id    <= r_gnt_id;
          r_rsp_valid <= 1'b1;
          r_state     <= DONE;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        DONE: begin
          r_rsp_valid <= 1'b0;
          r_rr_ptr    <= r_gnt_id == ID_W'(NUM_REQ - 1) ? '0 : r_gnt_id + 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef CLA_ARB_STATS_EN
  // Completed operations and non-idle cycles, both free-running and wrapping
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_op_count    <= '0;
      o_busy_cycles <= '0;
    end else begin
      o_op_count    <= o_op_count + (r_state == DONE ? 32'd1 : 32'd0);
      o_busy_cycles <= o_busy_cycles + (r_state != IDLE ? 32'd1 : 32'd0);
    end
  end
`endif
endmodule

// File: tb/tb_cla_add_arbiter.sv
// tb_cla_add_arbiter: directed tests for the shared-adder round-robin arbiter
module tb_cla_add_arbiter;
  localparam int N = 4, W = 64, L = 2, IW = 2;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [W-1:0]   add_a, add_b, add_sum, rsp_sum;
  logic           add_cout, rsp_valid, rsp_cout;
  logic [IW-1:0]  rsp_id;
`ifdef CLA_ARB_STATS_EN
  logic [31:0]    op_count, busy_cycles;
`endif
  int n_cmp = 0, n_err = 0;

  cla_add_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADD_LAT(L), .ID_W(IW)) dut (
    .i_clock(clk), .i_reset(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .o_add_a(add_a), .o_add_b(add_b),
    .i_add_sum(add_sum), .i_add_cout(add_cout), .o_rsp_valid(rsp_valid),
    .o_rsp_id(rsp_id), .o_rsp_sum(rsp_sum),
`ifdef CLA_ARB_STATS_EN
    .o_op_count(op_count), .o_busy_cycles(busy_cycles),
`endif
    .o_rsp_cout(rsp_cout));

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 4'b0101;
    step();
    step();
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_sum !== '0 || rsp_cout !== 1'b0 || rsp_id !== '0) begin n_err++; $display("FAIL reset_rsp: got sum=%h cout=%b id=%0d want 0/0/0", rsp_sum, rsp_cout, rsp_id); end
    n_cmp++; if (add_a !== '0 || add_b !== '0) begin n_err++; $display("FAIL reset_operands: got a=%h b=%h want 0", add_a, add_b); end
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
    req_valid = '0;
    #1;
  endtask

  task automatic test_single();
    logic [W-1:0] a = 64'h00FF_00FF_00FF_00FF, b = 64'hFF00_FF00_FF00_FF01;
    req_a[0 +: W] = a; req_b[0 +: W] = b; req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    n_cmp++; if (add_a !== a || add_b !== b) begin n_err++; $display("FAIL single_operands: got a=%h b=%h want a=%h b=%h", add_a, add_b, a, b); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early1: got rsp_valid=%b want 0", rsp_valid); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early2: got rsp_valid=%b want 0", rsp_valid); end
    step();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_sum !== 64'h0 || rsp_cout !== 1'b1 || rsp_id !== 2'd0) begin n_err++; $display("FAIL single_rsp: got v=%b sum=%h cout=%b id=%0d want 1/0/1/0", rsp_valid, rsp_sum, rsp_cout, rsp_id); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_cout !== 1'b1) begin n_err++; $display("FAIL single_after: got v=%b cout=%b want v=0 cout=1 held", rsp_valid, rsp_cout); end
  endtask

  task automatic test_req2();
    req_a[2*W +: W] = 64'h8080_8080_8080_80FF; req_b[2*W +: W] = 64'h8080_8080_8080_8001; req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL req2_ready: got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    step();
    step();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_sum !== 64'h0101_0101_0101_0100 || rsp_cout !== 1'b1 || rsp_id !== 2'd2) begin n_err++; $display("FAIL req2_rsp: got v=%b sum=%h cout=%b id=%0d want 1/0101010101010100/1/2", rsp_valid, rsp_sum, rsp_cout, rsp_id); end
    step();
  endtask

  task automatic test_round_robin();
    int ord [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 64'h1111_1111_1111_1111;
      req_b[i*W +: W] = 64'h2222_2222_2222_2222;
    end
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      exp = N'(1) << ord[g];
      n_cmp++; if (req_ready !== exp) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, exp); end
      step();
      n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rr_busy%0d: got ready=%b want 0000", g, req_ready); end
      step();
      step();
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== IW'(ord[g]) || rsp_sum !== 64'h3333_3333_3333_3333 || rsp_cout !== 1'b0) begin n_err++; $display("FAIL rr_rsp%0d: got v=%b id=%0d sum=%h cout=%b want 1/%0d/3333333333333333/0", g, rsp_valid, rsp_id, rsp_sum, rsp_cout, ord[g]); end
      if (g == 4) req_valid = '0;
      step();
    end
    n_cmp++; if (req_ready !== 4'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_idle: got ready=%b v=%b want 0000/0", req_ready, rsp_valid); end
  endtask

  task automatic test_hold();
    logic [W-1:0] a = 64'h0123_4567_89AB_CDEF, b = 64'h1111_1111_1111_1111;
    req_a[W +: W] = a; req_b[W +: W] = b; req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL hold_ready: got %b want 0010", req_ready); end
    step();
    req_valid = '0; req_a[W +: W] = ~a; req_b[W +: W] = 64'hDEAD_BEEF_0000_0001;
    for (int c = 0; c < L; c++) begin
      n_cmp++; if (add_a !== a || add_b !== b) begin n_err++; $display("FAIL hold_busy%0d: got a=%h b=%h want a=%h b=%h", c, add_a, add_b, a, b); end
      req_a[W +: W] = req_a[W +: W] + 64'd7;
      step();
    end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_sum !== 64'h1234_5678_9ABC_DF00 || rsp_cout !== 1'b0 || rsp_id !== 2'd1) begin n_err++; $display("FAIL hold_rsp: got v=%b sum=%h cout=%b id=%0d want 1/123456789abcdf00/0/1", rsp_valid, rsp_sum, rsp_cout, rsp_id); end
    step();
  endtask

  task automatic test_reset_mid();
    req_a[W +: W] = 64'd1; req_b[W +: W] = 64'd2; req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_ready: got %b want 0010", req_ready); end
    step();
    req_valid = 4'b1010; rst = 1'b1;
    step();
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0) begin n_err++; $display("FAIL mid_reset_cycle: got v=%b ready=%b want 0/0000", rsp_valid, req_ready); end
    n_cmp++; if (rsp_sum !== '0 || rsp_id !== '0 || add_a !== '0 || add_b !== '0) begin n_err++; $display("FAIL mid_cleared: got sum=%h id=%0d a=%h b=%h want all 0", rsp_sum, rsp_id, add_a, add_b); end
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_regrant: got %b want 0010", req_ready); end
    step();
    req_valid = 4'b1000;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_rsp: got v=%b want 0", rsp_valid); end
    step();
    step();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_sum !== 64'd3 || rsp_id !== 2'd1) begin n_err++; $display("FAIL mid_rsp: got v=%b sum=%h id=%0d want 1/3/1", rsp_valid, rsp_sum, rsp_id); end
    step();
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL mid_next: got %b want 1000", req_ready); end
    req_valid = '0;
    step();
  endtask

`ifdef CLA_ARB_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (op_count !== 32'd0 || busy_cycles !== 32'd0) begin n_err++; $display("FAIL stats_reset: got ops=%0d busy=%0d want 0/0", op_count, busy_cycles); end
    req_a[0 +: W] = 64'd5; req_b[0 +: W] = 64'd6; req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step();
      step();
      step();
      if (k == 2) req_valid = '0;
      step();
    end
    n_cmp++; if (op_count !== 32'd3 || busy_cycles !== 32'd9) begin n_err++; $display("FAIL stats_count: got ops=%0d busy=%0d want 3/9", op_count, busy_cycles); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_req2();
    test_round_robin();
    test_hold();
    test_reset_mid();
`ifdef CLA_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cla_add_arbiter.md
Name: cla_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 64-bit carry-lookahead adder among NUM_REQ requesters.
- Accepts one add request at a time over a valid/ready handshake.
- Drives the shared adder from registered operands and holds them for ADD_LAT settle cycles, then captures Sum/Cout.
- Returns the result tagged with the requester index. Sits between client datapaths and the purely combinational adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 64, operand/sum width; must match the adder
- ADD_LAT, 2, adder settle cycles before capture (>=1)
- ID_W, 2, width of rsp_id; must be >= ceil(log2(NUM_REQ))

Ports:
- clock  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot grant/accept strobe
- req_a  in  NUM_REQ*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B; same packing as req_a
- add_a  out  WIDTH  to shared adder operand A
- add_b  out  WIDTH  to shared adder operand B
- add_sum  in  WIDTH  from shared adder Sum
- add_cout  in  1  from shared adder Cout
- rsp_valid  out  1  result valid, one-cycle pulse
- rsp_id  out  ID_W  index of the requester that owns the result
- rsp_sum  out  WIDTH  registered sum
- rsp_cout  out  1  registered carry-out

Behaviour:
- Clock is clock; reset is synchronous, active-high. On reset:
  - state=IDLE, rr_ptr=0
  - operand regs=0, so add_a=add_b=0
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0
  - settle counter=0
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally; all other bits 0. req_ready is all zero outside IDLE or when no valid.
  - Handshake completes at the edge where req_valid[i] & req_ready[i]. At that edge: capture req_a/req_b slice i into operand regs, latch gnt_id=i, cnt=ADD_LAT-1, go to BUSY.
- BUSY:
  - add_a/add_b are held stable from the operand regs.
  - cnt decrements each cycle.
  - When cnt==0: capture add_sum/add_cout into rsp_sum/rsp_cout, rsp_id<=gnt_id, go to DONE.
- DONE:
  - rsp_valid=1 for exactly this one cycle; there is no back-pressure on the response.
  - rr_ptr <= (gnt_id+1) mod NUM_REQ; go to IDLE.
- Latency: handshake at edge T, so BUSY covers cycles T+1..T+ADD_LAT and rsp_valid is high in cycle T+ADD_LAT+1. Issue interval is ADD_LAT+2 cycles.
- rsp_sum/rsp_cout/rsp_id hold their value after DONE until the next capture. rsp_valid is 0 outside DONE.
- Requesters must hold req_valid and operands until req_ready. Deasserting req_valid before the grant withdraws the request with no side effect.
- req_valid changes during BUSY/DONE are ignored; arbitration is evaluated only in IDLE.
- Round-robin:
  - A requester continuously asserting req_valid is served within NUM_REQ grants.
  - Single requester: served every ADD_LAT+2 cycles.
- Wrap-around:
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Sums are modulo 2^WIDTH; overflow appears only on rsp_cout.
- Reset mid-operation (BUSY or DONE): the operation is discarded and no rsp_valid is produced. The next cycle is IDLE with rr_ptr=0.
- Reset while req_valid is asserted: no req_ready in the reset cycle; the first grant comes in the cycle after reset deasserts.

Optional Feature:
- Macro: CLA_ARB_STATS_EN.
- Defined:
  - Adds output op_count [31:0]: increments by 1 in each DONE cycle, wraps 0xFFFF_FFFF->0, cleared by reset.
  - Adds output busy_cycles [31:0]: increments every cycle state!=IDLE, wraps, cleared by reset.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Single requester 0, ADD_LAT=2: a=64'h00FF_00FF_00FF_00FF, b=64'hFF00_FF00_FF00_FF01, handshake at edge T -> rsp_valid only in cycle T+3 with rsp_sum=64'h0, rsp_cout=1, rsp_id=0.
- Requester 2: a=64'h8080_8080_8080_80FF, b=64'h8080_8080_8080_8001 -> rsp_sum=64'h0101_0101_0101_0100, rsp_cout=1, rsp_id=2.
- All 4 requesters valid continuously, each with a=64'h1111_1111_1111_1111, b=64'h2222_2222_2222_2222 -> grant order 0,1,2,3,0; each rsp_sum=64'h3333_3333_3333_3333, rsp_cout=0; grants 4 cycles apart.
- Check add_a/add_b stay constant throughout BUSY while the requester changes req_a/req_b after its handshake -> result reflects the captured operands only.
- Assert reset in the BUSY cycle after a grant to requester 1 -> no rsp_valid; all outputs 0 next cycle; with requesters 1 and 3 pending, the next grant goes to 1 (rr_ptr=0).
- With CLA_ARB_STATS_EN: 3 back-to-back ops at ADD_LAT=2 -> op_count=3, busy_cycles=9; without the macro the bench compiles without these ports.
